// File: rtl/id_rom_matcher.sv
// id_rom_matcher: sequential search of a registered ID ROM for a latched 10-digit BCD ID.
// Optional macro ID_BCD_CHECK_EN rejects non-BCD IDs without scanning; otherwise bad_id stays 0.
module id_rom_matcher #(
    parameter int N_ENTRIES = 5,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] id_in,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic [ADDR_W-1:0] match_idx,
    output logic              bad_id
);
    typedef enum logic [1:0] {IDLE, FETCH, CMP, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_ENTRIES - 1);
    state_t            state, state_n;
    logic [DATA_W-1:0] id_reg, id_reg_n;
    logic [ADDR_W-1:0] rom_addr_n, match_idx_n;
    logic              busy_n, done_n, match_n, bad_id_n, bcd_bad;
`ifdef ID_BCD_CHECK_EN
    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < DATA_W / 4; i++)
            if (id_in[4*i +: 4] > 4'd9) bcd_bad = 1'b1;
    end
`else
    assign bcd_bad = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            id_reg    <= '0;
            rom_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            match     <= 1'b0;
            match_idx <= '0;
            bad_id    <= 1'b0;
        end else begin
            state     <= state_n;
            id_reg    <= id_reg_n;
            rom_addr  <= rom_addr_n;
            busy      <= busy_n;
            done      <= done_n;
            match     <= match_n;
            match_idx <= match_idx_n;
            bad_id    <= bad_id_n;
        end
    end
    // done defaults low so every entry into DONE yields a single-cycle pulse
    always_comb begin
        state_n     = state;
        id_reg_n    = id_reg;
        rom_addr_n  = rom_addr;
        busy_n      = busy;
        done_n      = 1'b0;
        match_n     = match;
        match_idx_n = match_idx;
        bad_id_n    = bad_id;
        case (state)
            IDLE: if (start) begin
                id_reg_n    = id_in;
                rom_addr_n  = '0;
                match_n     = 1'b0;
                match_idx_n = '0;
                bad_id_n    = 1'b0;
                if (bcd_bad) begin
                    bad_id_n    = 1'b1;
                    match_idx_n = '1;
                    done_n      = 1'b1;
                    state_n     = DONE;
                end else begin
                    busy_n  = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: state_n = CMP;
            CMP: begin
                if (rom_data == id_reg || rom_addr == LAST) begin
                    match_n     = rom_data == id_reg;
                    match_idx_n = rom_data == id_reg ? rom_addr : '1;
                    busy_n      = 1'b0;
                    done_n      = 1'b1;
                    state_n     = DONE;
                end else begin
                    rom_addr_n = rom_addr + 1'b1;
                    state_n    = FETCH;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_id_rom_matcher.sv
// tb_id_rom_matcher: timeline model of the search plus directed literal checks.
module tb_id_rom_matcher;
    localparam int N = 5, AW = 4, DW = 40;
    logic clk = 0, rst = 1, start = 0;
    logic [DW-1:0] id_in = '0, rom_data = '0;
    logic [AW-1:0] rom_addr, match_idx;
    logic busy, done, match, bad_id;
    logic [DW-1:0] rom [16];
    int checks = 0, errors = 0;

    id_rom_matcher dut (.clk(clk), .rst(rst), .start(start), .id_in(id_in), .rom_addr(rom_addr),
                        .rom_data(rom_data), .busy(busy), .done(done), .match(match),
                        .match_idx(match_idx), .bad_id(bad_id));

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // model: per search, decision edge e and result derived from the ROM contents
    int t = 0, s0 = 0, e = -2, kk = 0;
    bit started = 0, hit = 0, bad = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            started = 0;
            e = -2;
        end else begin
            t++;
            if (start && t >= e + 2) begin
                s0 = t;
                bad = 0;
`ifdef ID_BCD_CHECK_EN
                for (int i = 0; i < DW / 4; i++) if (id_in[4*i +: 4] > 4'd9) bad = 1;
`endif
                hit = 0;
                kk = N - 1;
                for (int k = 0; k < N; k++) if (!hit && rom[k] == id_in) begin hit = 1; kk = k; end
                e = bad ? t : (hit ? t + 2 * kk + 2 : t + 2 * N);
                started = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            int ea;
            bit fin;
            fin = started && t >= e;
            ea = (!started || bad) ? 0 : ((t - s0) / 2 < kk ? (t - s0) / 2 : kk);
            chk("busy", busy, started && !bad && t < e);
            chk("done", done, started && t == e);
            chk("match", match, fin && hit);
            chk("match_idx", match_idx, fin ? (hit ? kk : 15) : 0);
            chk("bad_id", bad_id, fin && bad);
            chk("rom_addr", rom_addr, ea);
        end
    end

    task automatic wait_done(output int dt);
        dt = -1;
        for (int n = 0; n < 40; n++) begin
            if (done) begin dt = t - s0; break; end
            @(negedge clk);
        end
        chk("done_seen", dt >= 0, 1);
    endtask

    task automatic go(input logic [DW-1:0] id, output int dt);
        @(negedge clk);
        start = 1;
        id_in = id;
        @(negedge clk);
        start = 0;
        wait_done(dt);
    endtask

    initial begin
        int dt, d1, cnt;
        for (int i = 0; i < 16; i++) rom[i] = '0;
        rom[0] = 40'h1022440206;
        rom[1] = 40'h1015480227;
        rom[2] = 40'h1031122334;
        rom[3] = 40'h1015480227;
        rom[4] = 40'h1020833802;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_match", match, 0);
        chk("rst_idx", match_idx, 0);
        chk("rst_bad", bad_id, 0);
        chk("rst_addr", rom_addr, 0);
        rst = 0;
        repeat (2) @(negedge clk);
        go(40'h1022440206, dt);
        chk("t1_dt", dt, 2);
        chk("t1_match", match, 1);
        chk("t1_idx", match_idx, 0);
        @(negedge clk);
        chk("t1_busy_after", busy, 0);
        go(40'h1020833802, dt);
        chk("t2_dt", dt, 10);
        chk("t2_idx", match_idx, 4);
        go(40'h1234567890, dt);
        chk("t3_dt", dt, 10);
        chk("t3_match", match, 0);
        chk("t3_idx", match_idx, 4'hF);
        cnt = 0;
        repeat (6) begin @(negedge clk); cnt += int'(done); end
        chk("t3_one_pulse", cnt, 0);
        start = 1;
        id_in = 40'h1020833802;
        repeat (3) @(negedge clk);
        id_in = 40'h1015480227;
        wait_done(dt);
        chk("t4_first_idx", match_idx, 4);
        chk("t4_first_match", match, 1);
        d1 = t;
        @(negedge clk);
        wait_done(dt);
        start = 0;
        chk("t4_second_idx", match_idx, 1);
        chk("t4_gap", t - d1, 6);
        @(negedge clk);
        start = 1;
        id_in = 40'h1234567890;
        @(negedge clk);
        start = 0;
        for (int n = 0; n < 20 && rom_addr != 2; n++) @(negedge clk);
        chk("t5_reach_addr2", rom_addr, 2);
        #2 rst = 1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_addr", rom_addr, 0);
        chk("t5_match", match, 0);
        chk("t5_idx", match_idx, 0);
        chk("t5_bad", bad_id, 0);
        chk("t5_done", done, 0);
        @(negedge clk);
        rst = 0;
        cnt = 0;
        repeat (12) begin @(negedge clk); cnt += int'(done); end
        chk("t5_no_done", cnt, 0);
        go(40'h1015480227, dt);
        chk("t5_next_dt", dt, 4);
        chk("t5_next_idx", match_idx, 1);
        go(40'h10224402A6, dt);
`ifdef ID_BCD_CHECK_EN
        chk("t6_dt", dt, 0);
        chk("t6_bad", bad_id, 1);
        chk("t6_addr", rom_addr, 0);
`else
        chk("t6_dt", dt, 10);
        chk("t6_bad", bad_id, 0);
        chk("t6_addr", rom_addr, 4);
`endif
        chk("t6_match", match, 0);
        chk("t6_idx", match_idx, 4'hF);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
